// File: rtl/data_mem_hs_pkg.sv
// Shared encodings for the handshaked data memory: access sizes, FSM states, byte-enable helper.
// Purely declarative; no timing or backpressure of its own.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response valid-ready bundle between the MEM stage (master) and the data memory (slave).
// One request in flight; the master holds rsp_ready low to stall the response.
interface data_mem_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_size, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_size, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
// Combinational, zero latency; no backpressure.
module data_mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_offset +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Parametrised data memory with byte/half/word access and error flagging, one transaction in flight.
// Response valid WAIT_STATES+1 edges after accept; held stable until rsp_ready; req_ready low while busy.
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  data_mem_hs_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rword;
  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  size_e       r_size;
  logic [1:0]  r_off;
  logic        r_signed, r_err, r_write;

  logic          w_accept, w_err, w_misaligned, w_out_of_range;
  size_e         w_size;
  logic [31:0]   w_offs, w_wdata_lanes, w_ext;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;

  assign w_size         = size_e'(bus.req_size);
  assign w_offs         = bus.req_addr - BASE_ADDR;
  assign w_idx          = w_offs[AW+1:2];
  // BASE_ADDR is aligned to the array size, so the offset's low bits are the lane
  assign w_misaligned   = ((w_size == SZ_HALF) && w_offs[0]) ||
                          ((w_size == SZ_WORD) && (w_offs[1:0] != 2'b00));
  assign w_out_of_range = (w_offs[31:AW+2] != '0);
  assign w_err          = w_misaligned || w_out_of_range || (w_size == SZ_ILL);
  assign w_be           = byte_en(w_size, w_offs[1:0]);
  assign w_accept       = (r_state == IDLE) && bus.req_valid;

  always_comb begin
    w_wdata_lanes = bus.req_wdata;
    case (w_size)
      SZ_BYTE: w_wdata_lanes = {4{bus.req_wdata[7:0]}};
      SZ_HALF: w_wdata_lanes = {2{bus.req_wdata[15:0]}};
      default: w_wdata_lanes = bus.req_wdata;
    endcase
  end

  // Array and read register are deliberately outside reset
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_rword <= r_mem[w_idx];
      if (bus.req_write && !w_err) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_size   <= SZ_BYTE;
      r_off    <= '0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_size   <= w_size;
        r_off    <= w_offs[1:0];
        r_signed <= bus.req_signed;
        r_err    <= w_err;
        r_write  <= bus.req_write;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  data_mem_load_align u_align (
    .i_word   (r_rword),
    .i_offset (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = (r_state == RESP) && r_err;
  assign bus.rsp_rdata = ((r_state == RESP) && !r_err && !r_write) ? w_ext : '0;

endmodule
